// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius (Simon) game engine.
// States, LFSR polynomial/default seed and symbol-to-one-hot conversion.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GEN       = 3'd1,
    ST_SHOW_ON   = 3'd2,
    ST_SHOW_OFF  = 3'd3,
    ST_WAIT_USER = 3'd4,
    ST_WIN       = 3'd5,
    ST_LOSE      = 3'd6
  } state_e;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [7:0] sym_to_onehot(input logic [2:0] sym);
    logic [7:0] oh;
    oh      = 8'd0;
    oh[sym] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// 16-bit Fibonacci LFSR that free-runs every cycle; load replaces the step
// with the seed (a zero seed falls back to the default seed).
module genius_lfsr
  import genius_pkg::*;
(
  input  logic        clock,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  output logic [7:0]  byte_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: seed load or one shift step
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      if (seed_i == 16'd0) begin
        lfsr_d = LFSR_DEFAULT_SEED;
      end else begin
        lfsr_d = seed_i;
      end
    end else begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // LFSR state register
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= LFSR_DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign byte_o = lfsr_q[7:0];

endmodule

// File: rtl/genius_core.sv
// Genius (Simon) game engine: grows a random sequence, plays it, checks replay.
// Optional GENIUS_SPEEDUP_EN halves the LED-on time every 8 rounds (down to 1/8).
module genius_core
  import genius_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int MAX_LEN     = 32,
  parameter int SHOW_CYC    = 25_000_000,
  parameter int GAP_CYC     = 12_500_000,
  parameter int TIMEOUT_CYC = 250_000_000,
  localparam int SYM_W      = $clog2(N_CH),
  localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [15:0]       seed_i,
  input  logic [N_CH-1:0]   btn_i,
  output logic [N_CH-1:0]   led_o,
  output logic [LEN_W-1:0]  round_o,
  output logic              user_turn_o,
  output logic              win_o,
  output logic              lose_o
);

  localparam int CNT_MAX_SG = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int CNT_MAX    = (CNT_MAX_SG > TIMEOUT_CYC) ? CNT_MAX_SG : TIMEOUT_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_q;
  logic [N_CH-1:0]     btn_q;
  logic [N_CH-1:0]     led_q, led_d;
  logic [LEN_W-1:0]    round_q, round_d;
  logic                user_turn_q, user_turn_d;
  logic                win_q, win_d;
  logic                lose_q, lose_d;

  logic [SYM_W-1:0]    mem_q [MAX_LEN];
  logic                mem_we_s;
  logic [SYM_W-1:0]    new_sym_s;
  logic                lfsr_load_s;
  logic [7:0]          lfsr_byte_s;
  logic                start_edge_s;
  logic [N_CH-1:0]     btn_rise_s;
  logic [N_CH-1:0]     exp_oh_s;
  logic [CNT_W-1:0]    show_s;

  genius_lfsr u_lfsr (
    .clock   (clock),
    .reset_i (reset_i),
    .load_i  (lfsr_load_s),
    .seed_i  (seed_i),
    .byte_o  (lfsr_byte_s)
  );

  // Edge detection, current symbol decode and new-symbol draw
  always_comb begin
    start_edge_s = start_i & ~start_q;
    btn_rise_s   = btn_i & ~btn_q;
    exp_oh_s     = N_CH'(sym_to_onehot(3'(mem_q[idx_q[AW-1:0]])));
    new_sym_s    = SYM_W'(lfsr_byte_s % 8'(N_CH));
  end

`ifdef GENIUS_SPEEDUP_EN
  logic [LEN_W-1:0] len_div8_s;
  logic [1:0]       shift_s;

  // Playback shortens by one halving every 8 rounds, at most three times
  always_comb begin
    len_div8_s = LEN_W'((len_q - LEN_W'(1)) >> 3);
    if (len_div8_s >= LEN_W'(3)) begin
      shift_s = 2'd3;
    end else begin
      shift_s = 2'(len_div8_s);
    end
    show_s = CNT_W'(SHOW_CYC) >> shift_s;
  end
`else
  // Fixed LED-on time
  always_comb begin
    show_s = CNT_W'(SHOW_CYC);
  end
`endif

  // Next-state logic for the game controller
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    lfsr_load_s = 1'b0;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start_edge_s) begin
          lfsr_load_s = 1'b1;
          len_d       = LEN_W'(0);
          state_d     = ST_GEN;
        end else begin
          state_d     = state_q;
        end
      end
      ST_GEN: begin
        mem_we_s = 1'b1;
        len_d    = len_q + LEN_W'(1);
        idx_d    = LEN_W'(0);
        cnt_d    = CNT_W'(0);
        state_d  = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (cnt_q == show_s - CNT_W'(1)) begin
          cnt_d   = CNT_W'(0);
          state_d = ST_SHOW_OFF;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_SHOW_OFF: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d = CNT_W'(0);
          if (idx_q + LEN_W'(1) == len_q) begin
            idx_d   = LEN_W'(0);
            state_d = ST_WAIT_USER;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = ST_SHOW_ON;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_USER: begin
        // A press in the timeout cycle wins over the timeout
        if (btn_rise_s != '0) begin
          if (btn_rise_s == exp_oh_s) begin
            cnt_d = CNT_W'(0);
            if (idx_q + LEN_W'(1) == len_q) begin
              if (len_q == LEN_W'(MAX_LEN)) begin
                state_d = ST_WIN;
              end else begin
                state_d = ST_GEN;
              end
            end else begin
              idx_d = idx_q + LEN_W'(1);
            end
          end else begin
            state_d = ST_LOSE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_LOSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values, registered one cycle behind the state
  always_comb begin
    led_d       = '0;
    user_turn_d = 1'b0;
    win_d       = 1'b0;
    lose_d      = 1'b0;
    round_d     = len_q;
    case (state_q)
      ST_SHOW_ON: begin
        led_d = exp_oh_s;
      end
      ST_WAIT_USER: begin
        led_d       = btn_i;
        user_turn_d = 1'b1;
      end
      ST_WIN: begin
        led_d = {N_CH{1'b1}};
        win_d = 1'b1;
      end
      ST_LOSE: begin
        led_d  = exp_oh_s;
        lose_d = 1'b1;
      end
      default: begin
        led_d = '0;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      len_q       <= LEN_W'(0);
      idx_q       <= LEN_W'(0);
      cnt_q       <= CNT_W'(0);
      start_q     <= 1'b0;
      btn_q       <= '0;
      led_q       <= '0;
      round_q     <= LEN_W'(0);
      user_turn_q <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      start_q     <= start_i;
      btn_q       <= btn_i;
      led_q       <= led_d;
      round_q     <= round_d;
      user_turn_q <= user_turn_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  // Sequence memory survives reset
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[len_q[AW-1:0]] <= new_sym_s;
    end
  end

  assign led_o       = led_q;
  assign round_o     = round_q;
  assign user_turn_o = user_turn_q;
  assign win_o       = win_q;
  assign lose_o      = lose_q;

endmodule

// File: doc/genius_core.md
# genius_core

Parametrised game engine for the Genius (Simon) memory game, successor to the fixed four-button datapath/control pair. It holds a randomly grown symbol sequence of up to `MAX_LEN` entries over `N_CH` button/LED channels, plays the sequence on the LEDs, checks the player's replay with a per-press timeout, and reports round, win and loss. It sits between debounced board inputs (`KEY`/`SW`) and the LED/7-segment display logic.

## Interface
- `N_CH`, 4: number of button/LED channels, 2..8; `SYM_W = $clog2(N_CH)`.
- `MAX_LEN`, 32: sequence length needed to win, 1..256; `LEN_W = $clog2(MAX_LEN+1)`.
- `SHOW_CYC`, 25_000_000: LED-on cycles per played symbol (0.5 s at 50 MHz), ≥8.
- `GAP_CYC`, 12_500_000: LED-off cycles after each played symbol, ≥1.
- `TIMEOUT_CYC`, 250_000_000: maximum cycles allowed per player press.
- `clock` in 1: the only clock, 50 MHz, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: level input; its rising edge starts a game.
- `seed_i` in 16: LFSR seed, latched at game start.
- `btn_i` in N_CH: debounced button levels, active-high.
- `led_o` out N_CH: channel LEDs.
- `round_o` out LEN_W: current sequence length, 0 when idle.
- `user_turn_o` out 1: high while the block waits for player input.
- `win_o`, `lose_o` out 1: held high in WIN and LOSE respectively.

## Operation
- States: IDLE, GEN, SHOW_ON, SHOW_OFF, WAIT_USER, WIN, LOSE.
- Reset values: state IDLE, all outputs 0, length 0, LFSR 16'hACE1, and the edge-detect registers for `start_i` and `btn_i` are cleared.
- Reset asserted mid-game aborts to IDLE immediately. Sequence memory contents are not cleared.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in every state.
- Start: a `start_i` rising edge in IDLE, WIN or LOSE loads the LFSR from `seed_i` (0 is replaced by 16'hACE1), clears length, and goes to GEN. In all other states the edge is ignored.
- GEN (1 cycle): `mem[length] <= lfsr[7:0] % N_CH`; length increments; play index clears; go to SHOW_ON.
- SHOW_ON: `led_o` is one-hot of `mem[index]` for show-time cycles, then go to SHOW_OFF.
- SHOW_OFF: `led_o` is 0 for GAP_CYC cycles. Then the index increments. If index equals length, go to WAIT_USER with index 0 and the timeout counter cleared; otherwise go back to SHOW_ON.
- WAIT_USER:
  - `led_o = btn_i` (echo) and `user_turn_o` is 1.
  - A press is a cycle in which the set of newly rising `btn_i` bits is non-empty.
  - Exactly one rising bit that equals `mem[index]` is correct: the index increments and the timeout counter clears.
  - A wrong bit, or two or more bits rising in the same cycle, goes to LOSE.
  - On a correct last press: length equal to MAX_LEN goes to WIN, otherwise to GEN.
  - If the timeout counter reaches TIMEOUT_CYC, go to LOSE. A press arriving in the same cycle as the timeout takes priority over the timeout.
- WIN: `led_o` all ones, `win_o` = 1. LOSE: `led_o` is one-hot of the expected symbol, `lose_o` = 1. Both states hold until a start edge or reset.
- `round_o` equals length in all states; it reads 0 in IDLE.

## Timing
- All outputs are registered and change one cycle after the state change that causes them.
- Start edge at cycle n: GEN at n+1, first LED lit at n+3.
- A round of length L plays for `L*(show+GAP_CYC)` cycles.
- A press sampled at cycle n produces its next-state effect at n+1. There is no input buffering: presses outside WAIT_USER are discarded.
- Counters are sized `$clog2(max(SHOW_CYC, GAP_CYC, TIMEOUT_CYC)+1)` bits and never wrap.

## Configuration
- `GENIUS_SPEEDUP_EN`:
  - Defined: show time = `SHOW_CYC >> min((length-1)/8, 3)`, so playback gets faster every 8 rounds, down to 1/8 of SHOW_CYC.
  - Undefined: show time is always SHOW_CYC.
- GAP_CYC and TIMEOUT_CYC are unaffected in both cases.

## Structure
- Package `genius_pkg` holds the state enum, the LFSR taps, the default seed 16'hACE1, and a one-hot conversion function.
- Sub-module `genius_lfsr` (16-bit, load/seed port). Sequence memory is an inferred register array of MAX_LEN×SYM_W bits.

## Test plan
Unless stated otherwise, the bench uses N_CH=4, MAX_LEN=3, SHOW_CYC=8, GAP_CYC=2, TIMEOUT_CYC=20, seed 16'h1234.
- Start pulse → `round_o`=1; `led_o` is one-hot for 8 cycles and then 0 for 2 cycles; first LED appears 3 cycles after the edge; `user_turn_o` rises after the gap.
- Replay the correct symbols each round for 3 rounds → `win_o`=1, `led_o`=4'hF, `round_o`=3; a new start edge → `round_o`=1.
- Wrong button in round 2 → `lose_o`=1, `led_o` shows the expected symbol, `round_o`=2.
- Two buttons rising in the same cycle → LOSE. No press for 20 cycles → LOSE. A correct press at cycle 19 → play continues.
- `reset_i` asserted during SHOW_ON → all outputs 0 in the same cycle; a start edge after release replays an identical sequence for the same seed.
- With `GENIUS_SPEEDUP_EN`, MAX_LEN=10, SHOW_CYC=16: round 9 LED-on duration is 8 cycles versus 16 in round 1.
